// File: rtl/mem_port_arbiter.sv
// Single memory port shared by instruction fetch and the data stage.
// One transaction at a time; MEM wins ties until IF has waited too long.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MEM_STREAK_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_busy_o,
  output logic                if_done_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic [DATA_W/8-1:0] mem_wmask_i,
  output logic                mem_busy_o,
  output logic                mem_done_o,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                port_req_o,
  output logic                port_we_o,
  output logic [ADDR_W-1:0]   port_addr_o,
  output logic [DATA_W-1:0]   port_wdata_o,
  output logic [DATA_W/8-1:0] port_wmask_o,
  input  logic [DATA_W-1:0]   port_rdata_i,
  input  logic                port_ack_i
);

  localparam int MW = DATA_W / 8;
  localparam int SW = $clog2(MEM_STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MEM_STREAK_MAX);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_IF,
    SERVE_MEM
  } state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MW-1:0]     mask_q, mask_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

  logic              if_forced;
  logic              grant_mem;
  logic              grant_if;

  // IF is forced only once MEM has taken the maximum run of contested grants
  assign if_forced = if_req_i && (streak_q == STREAK_MAX);
  assign grant_mem = (state_q == IDLE) && mem_req_i && !if_forced;
  assign grant_if  = (state_q == IDLE) && if_req_i && !grant_mem;

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (grant_mem) begin
          state_d = SERVE_MEM;
          we_d    = mem_we_i;
          addr_d  = mem_addr_i;
          wdata_d = mem_wdata_i;
          mask_d  = mem_we_i ? mem_wmask_i : '0;
          if (!if_req_i) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (grant_if) begin
          state_d  = SERVE_IF;
          we_d     = 1'b0;
          addr_d   = if_addr_i;
          wdata_d  = '0;
          mask_d   = '0;
          streak_d = '0;
        end
      end
      SERVE_IF: begin
        if (port_ack_i) begin
          state_d    = IDLE;
          if_done_d  = 1'b1;
          if_rdata_d = port_rdata_i;
        end
      end
      SERVE_MEM: begin
        if (port_ack_i) begin
          state_d    = IDLE;
          mem_done_d = 1'b1;
          if (!we_q) begin
            mem_rdata_d = port_rdata_i;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign port_req_o   = (state_q == SERVE_IF) || (state_q == SERVE_MEM);
  assign port_we_o    = we_q;
  assign port_addr_o  = addr_q;
  assign port_wdata_o = wdata_q;
  assign port_wmask_o = mask_q;

  assign if_done_o   = if_done_q;
  assign mem_done_o  = mem_done_q;
  assign if_rdata_o  = if_rdata_q;
  assign mem_rdata_o = mem_rdata_q;

  assign if_busy_o  = if_req_i & ~if_done_q;
  assign mem_busy_o = mem_req_i & ~mem_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level
// model of the shared memory port.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MW  = DW / 8;
  localparam int MAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_busy_o;
  logic          if_done_o;
  logic [DW-1:0] if_rdata_o;
  logic          mem_req_i;
  logic          mem_we_i;
  logic [AW-1:0] mem_addr_i;
  logic [DW-1:0] mem_wdata_i;
  logic [MW-1:0] mem_wmask_i;
  logic          mem_busy_o;
  logic          mem_done_o;
  logic [DW-1:0] mem_rdata_o;
  logic          port_req_o;
  logic          port_we_o;
  logic [AW-1:0] port_addr_o;
  logic [DW-1:0] port_wdata_o;
  logic [MW-1:0] port_wmask_o;
  logic [DW-1:0] port_rdata_i;
  logic          port_ack_i;

  int vectors = 0;
  int miscompares = 0;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_STREAK_MAX(MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_busy_o(if_busy_o), .if_done_o(if_done_o),
    .if_rdata_o(if_rdata_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_wmask_i(mem_wmask_i),
    .mem_busy_o(mem_busy_o), .mem_done_o(mem_done_o),
    .mem_rdata_o(mem_rdata_o),
    .port_req_o(port_req_o), .port_we_o(port_we_o),
    .port_addr_o(port_addr_o), .port_wdata_o(port_wdata_o),
    .port_wmask_o(port_wmask_o),
    .port_rdata_i(port_rdata_i), .port_ack_i(port_ack_i)
  );

  always #5 clk = ~clk;

  // Reference: who owns the port, what was granted, and MEM's contested run
  typedef enum {NONE, OWN_IF, OWN_MEM} own_e;
  own_e          m_own = NONE;
  int            m_run = 0;
  logic [AW-1:0] m_addr = '0;
  logic          m_we = 1'b0;
  logic [DW-1:0] m_wdata = '0;
  logic [MW-1:0] m_mask = '0;
  logic          m_if_done = 1'b0;
  logic          m_mem_done = 1'b0;
  logic [DW-1:0] m_if_rdata = '0;
  logic [DW-1:0] m_mem_rdata = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_own = NONE;
      m_run = 0;
      m_addr = '0;
      m_we = 1'b0;
      m_wdata = '0;
      m_mask = '0;
      m_if_done = 1'b0;
      m_mem_done = 1'b0;
      m_if_rdata = '0;
      m_mem_rdata = '0;
    end else begin
      m_if_done = 1'b0;
      m_mem_done = 1'b0;
      if (m_own == OWN_IF && port_ack_i) begin
        m_if_done = 1'b1;
        m_if_rdata = port_rdata_i;
        m_own = NONE;
      end else if (m_own == OWN_MEM && port_ack_i) begin
        m_mem_done = 1'b1;
        if (!m_we) m_mem_rdata = port_rdata_i;
        m_own = NONE;
      end else if (m_own == NONE) begin
        if (mem_req_i && !(if_req_i && m_run >= MAX)) begin
          m_own = OWN_MEM;
          m_addr = mem_addr_i;
          m_we = mem_we_i;
          m_wdata = mem_wdata_i;
          m_mask = mem_we_i ? mem_wmask_i : '0;
          m_run = if_req_i ? ((m_run < MAX) ? m_run + 1 : MAX) : 0;
        end else if (if_req_i) begin
          m_own = OWN_IF;
          m_addr = if_addr_i;
          m_we = 1'b0;
          m_mask = '0;
          m_run = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0;
    if_req_i = 1'b0;
    if_addr_i = '0;
    mem_req_i = 1'b0;
    mem_we_i = 1'b0;
    mem_addr_i = '0;
    mem_wdata_i = '0;
    mem_wmask_i = '0;
    port_rdata_i = '0;
    port_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (port_req_o !== 1'b0 || port_we_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_port: req=%b we=%b want 0 0", port_req_o, port_we_o);
    end
    vectors++;
    if (port_addr_o !== '0 || port_wdata_o !== '0 || port_wmask_o !== '0) begin
      miscompares++;
      $display("FAIL reset_fields: addr=%h wdata=%h mask=%b want 0",
               port_addr_o, port_wdata_o, port_wmask_o);
    end
    vectors++;
    if (if_done_o !== 1'b0 || mem_done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done: if=%b mem=%b want 0 0", if_done_o, mem_done_o);
    end
    vectors++;
    if (if_rdata_o !== '0 || mem_rdata_o !== '0) begin
      miscompares++;
      $display("FAIL reset_rdata: if=%h mem=%h want 0", if_rdata_o, mem_rdata_o);
    end
  endtask

  task automatic test_if_fetch();
    if_req_i = 1'b1;
    if_addr_i = 32'h10;
    #1;
    vectors++;
    if (if_busy_o !== 1'b1 || port_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_raise: busy=%b req=%b want 1 0", if_busy_o, port_req_o);
    end
    tick();
    vectors++;
    if (port_req_o !== 1'b1 || port_addr_o !== 32'h10 || port_we_o !== 1'b0
        || port_wmask_o !== '0) begin
      miscompares++;
      $display("FAIL fetch_grant: req=%b addr=%h we=%b mask=%b want 1 10 0 0",
               port_req_o, port_addr_o, port_we_o, port_wmask_o);
    end
    tick();
    vectors++;
    if (port_req_o !== 1'b1 || port_addr_o !== 32'h10 || if_done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_hold: req=%b addr=%h done=%b want 1 10 0",
               port_req_o, port_addr_o, if_done_o);
    end
    port_ack_i = 1'b1;
    port_rdata_i = 32'h00500093;
    tick();
    port_ack_i = 1'b0;
    port_rdata_i = 32'hFFFF_FFFF;
    #1;
    vectors++;
    if (if_done_o !== 1'b1 || if_busy_o !== 1'b0 || port_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_done: done=%b busy=%b req=%b want 1 0 0",
               if_done_o, if_busy_o, port_req_o);
    end
    vectors++;
    if (if_rdata_o !== 32'h00500093) begin
      miscompares++;
      $display("FAIL fetch_rdata: got %h want 00500093", if_rdata_o);
    end
    if_req_i = 1'b0;
    tick();
    vectors++;
    if (if_done_o !== 1'b0 || if_rdata_o !== 32'h00500093) begin
      miscompares++;
      $display("FAIL fetch_after: done=%b rdata=%h want 0 00500093",
               if_done_o, if_rdata_o);
    end
  endtask

  task automatic test_simultaneous();
    if_req_i = 1'b1;
    if_addr_i = 32'h20;
    mem_req_i = 1'b1;
    mem_we_i = 1'b0;
    mem_addr_i = 32'h1000;
    tick();
    vectors++;
    if (port_req_o !== 1'b1 || port_addr_o !== 32'h1000 || if_busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_mem_first: req=%b addr=%h ifbusy=%b want 1 1000 1",
               port_req_o, port_addr_o, if_busy_o);
    end
    port_ack_i = 1'b1;
    port_rdata_i = 32'hCAFE0001;
    tick();
    port_ack_i = 1'b0;
    vectors++;
    if (mem_done_o !== 1'b1 || mem_rdata_o !== 32'hCAFE0001 || if_busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_mem_done: done=%b rdata=%h ifbusy=%b want 1 cafe0001 1",
               mem_done_o, mem_rdata_o, if_busy_o);
    end
    mem_req_i = 1'b0;
    tick();
    vectors++;
    if (port_req_o !== 1'b1 || port_addr_o !== 32'h20 || if_busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_if_next: req=%b addr=%h ifbusy=%b want 1 20 1",
               port_req_o, port_addr_o, if_busy_o);
    end
    port_ack_i = 1'b1;
    port_rdata_i = 32'h00A00113;
    tick();
    port_ack_i = 1'b0;
    vectors++;
    if (if_done_o !== 1'b1 || if_rdata_o !== 32'h00A00113) begin
      miscompares++;
      $display("FAIL simul_if_done: done=%b rdata=%h want 1 00a00113",
               if_done_o, if_rdata_o);
    end
    if_req_i = 1'b0;
    tick();
  endtask

  task automatic test_mem_store();
    mem_req_i = 1'b1;
    mem_we_i = 1'b1;
    mem_addr_i = 32'h2004;
    mem_wdata_i = 32'hDEADBEEF;
    mem_wmask_i = 4'b0011;
    tick();
    for (int c = 0; c < 2; c++) begin
      vectors++;
      if (port_req_o !== 1'b1 || port_we_o !== 1'b1 || port_wmask_o !== 4'b0011
          || port_wdata_o !== 32'hDEADBEEF || port_addr_o !== 32'h2004) begin
        miscompares++;
        $display("FAIL store_port c%0d: req=%b we=%b mask=%b wdata=%h addr=%h",
                 c, port_req_o, port_we_o, port_wmask_o, port_wdata_o, port_addr_o);
      end
      mem_wmask_i = 4'b1111;
      mem_wdata_i = 32'h0;
      if (c == 0) tick();
    end
    port_ack_i = 1'b1;
    port_rdata_i = 32'h12345678;
    tick();
    port_ack_i = 1'b0;
    vectors++;
    if (mem_done_o !== 1'b1 || mem_rdata_o !== 32'hCAFE0001) begin
      miscompares++;
      $display("FAIL store_done: done=%b rdata=%h want 1 cafe0001",
               mem_done_o, mem_rdata_o);
    end
    mem_req_i = 1'b0;
    mem_we_i = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    int cnt;
    bit is_if;
    if_req_i = 1'b1;
    if_addr_i = 32'h40;
    mem_req_i = 1'b1;
    mem_we_i = 1'b0;
    mem_addr_i = 32'h3000;
    for (int k = 0; k < 6; k++) begin
      cnt = 0;
      while (!port_req_o && cnt < 10) begin
        tick();
        cnt++;
      end
      vectors++;
      if (!port_req_o) begin
        miscompares++;
        $display("FAIL starve_timeout k%0d: no grant in 10 cycles", k);
      end
      is_if = (port_addr_o == 32'h40);
      vectors++;
      if (is_if !== (k == 4)) begin
        miscompares++;
        $display("FAIL starve_order k%0d: got %s want %s", k,
                 is_if ? "IF" : "MEM", (k == 4) ? "IF" : "MEM");
      end
      port_ack_i = 1'b1;
      tick();
      port_ack_i = 1'b0;
    end
    if_req_i = 1'b0;
    mem_req_i = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    if_req_i = 1'b1;
    if_addr_i = 32'h50;
    tick();
    mem_req_i = 1'b1;
    mem_we_i = 1'b0;
    mem_addr_i = 32'h4000;
    if_req_i = 1'b0;
    tick();
    vectors++;
    if (port_req_o !== 1'b1 || port_addr_o !== 32'h50) begin
      miscompares++;
      $display("FAIL flush_kept: req=%b addr=%h want 1 50", port_req_o, port_addr_o);
    end
    port_ack_i = 1'b1;
    port_rdata_i = 32'h0BADF00D;
    tick();
    port_ack_i = 1'b0;
    vectors++;
    if (if_done_o !== 1'b1 || if_rdata_o !== 32'h0BADF00D || mem_busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_done: done=%b rdata=%h membusy=%b want 1 0badf00d 1",
               if_done_o, if_rdata_o, mem_busy_o);
    end
    tick();
    vectors++;
    if (if_done_o !== 1'b0 || port_req_o !== 1'b1 || port_addr_o !== 32'h4000) begin
      miscompares++;
      $display("FAIL flush_next: ifdone=%b req=%b addr=%h want 0 1 4000",
               if_done_o, port_req_o, port_addr_o);
    end
    port_ack_i = 1'b1;
    tick();
    port_ack_i = 1'b0;
    mem_req_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_midop();
    if_req_i = 1'b1;
    if_addr_i = 32'h10;
    tick();
    vectors++;
    if (port_req_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_grant: req=%b want 1", port_req_o);
    end
    rst = 1'b1;
    if_req_i = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (port_req_o !== 1'b0 || if_done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_drop: req=%b done=%b want 0 0", port_req_o, if_done_o);
    end
    port_ack_i = 1'b1;
    port_rdata_i = 32'h77777777;
    tick();
    port_ack_i = 1'b0;
    vectors++;
    if (if_done_o !== 1'b0 || port_req_o !== 1'b0 || if_rdata_o !== '0) begin
      miscompares++;
      $display("FAIL rstmid_ack: done=%b req=%b rdata=%h want 0 0 0",
               if_done_o, port_req_o, if_rdata_o);
    end
  endtask

  task automatic test_random();
    logic e_req;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(99) == 0);
      if_req_i = ($urandom_range(2) != 0);
      if_addr_i = $urandom;
      mem_req_i = ($urandom_range(2) != 0);
      mem_we_i = $urandom_range(1);
      mem_addr_i = $urandom;
      mem_wdata_i = $urandom;
      mem_wmask_i = MW'($urandom);
      port_rdata_i = $urandom;
      port_ack_i = ($urandom_range(2) == 0);
      #1;
      e_req = (m_own != NONE);
      vectors++;
      if (port_req_o !== e_req) begin
        miscompares++;
        $display("FAIL rnd_req n%0d: got %b want %b", n, port_req_o, e_req);
      end
      vectors++;
      if (e_req && (port_addr_o !== m_addr || port_we_o !== m_we
          || port_wmask_o !== m_mask || (m_we && port_wdata_o !== m_wdata))) begin
        miscompares++;
        $display("FAIL rnd_port n%0d: addr=%h we=%b mask=%b wdata=%h want %h %b %b %h",
                 n, port_addr_o, port_we_o, port_wmask_o, port_wdata_o,
                 m_addr, m_we, m_mask, m_wdata);
      end
      vectors++;
      if (if_done_o !== m_if_done || mem_done_o !== m_mem_done) begin
        miscompares++;
        $display("FAIL rnd_done n%0d: if=%b mem=%b want %b %b",
                 n, if_done_o, mem_done_o, m_if_done, m_mem_done);
      end
      vectors++;
      if (if_rdata_o !== m_if_rdata || mem_rdata_o !== m_mem_rdata) begin
        miscompares++;
        $display("FAIL rnd_rdata n%0d: if=%h mem=%h want %h %h",
                 n, if_rdata_o, mem_rdata_o, m_if_rdata, m_mem_rdata);
      end
      vectors++;
      if (if_busy_o !== (if_req_i && !m_if_done)
          || mem_busy_o !== (mem_req_i && !m_mem_done)) begin
        miscompares++;
        $display("FAIL rnd_busy n%0d: if=%b mem=%b", n, if_busy_o, mem_busy_o);
      end
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    #2;
    test_reset();
    test_if_fetch();
    test_simultaneous();
    test_mem_store();
    test_starvation();
    test_flush();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Single-ported memory shared between instruction fetch (IF) and the data access stage (MEM).
- Arbitrates between the two requesters, sequences one transaction at a time on the memory port, and returns per-requester busy/done/data.
- Replaces per-stage ad-hoc ROM handshaking: stages hold a level request until a one-cycle done pulse.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte mask width is DATA_W/8.
- MEM_STREAK_MAX, 4, max consecutive MEM grants while IF is waiting; then IF is forced.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- if_req_i  in  1  IF read request (level, held until if_done_o).
- if_addr_i  in  ADDR_W  IF fetch address.
- if_busy_o  out  1  IF request pending and not yet complete.
- if_done_o  out  1  one-cycle pulse: if_rdata_o valid.
- if_rdata_o  out  DATA_W  fetched instruction, held until next IF done.
- mem_req_i  in  1  MEM stage request (level, held until mem_done_o).
- mem_we_i  in  1  1 = write, 0 = read.
- mem_addr_i  in  ADDR_W  data address.
- mem_wdata_i  in  DATA_W  store data.
- mem_wmask_i  in  DATA_W/8  byte enables for stores.
- mem_busy_o  out  1  MEM request pending and not yet complete.
- mem_done_o  out  1  one-cycle pulse: transaction finished; mem_rdata_o valid on reads.
- mem_rdata_o  out  DATA_W  load data, held until next MEM done.
- port_req_o  out  1  memory port request, held until port_ack_i.
- port_we_o  out  1  write strobe for current transaction.
- port_addr_o  out  ADDR_W  address.
- port_wdata_o  out  DATA_W  write data.
- port_wmask_o  out  DATA_W/8  byte enables; all zero on reads.
- port_rdata_i  in  DATA_W  read data, valid with port_ack_i.
- port_ack_i  in  1  transaction-complete pulse from memory.

Behaviour:
- Reset (rst sampled high at posedge):
  - State returns to IDLE; streak counter cleared.
  - All port_* outputs, done pulses and rdata registers go to 0.
  - Applies mid-transaction too: port_req_o drops at that edge, the in-flight ack is discarded, and no done is pulsed.
- FSM states: IDLE, SERVE_IF, SERVE_MEM.
- In IDLE, grant decision at the clock edge:
  - Only mem_req_i high → SERVE_MEM.
  - Only if_req_i high → SERVE_IF.
  - Both high → SERVE_MEM, unless streak == MEM_STREAK_MAX, in which case SERVE_IF.
  - Neither → stay IDLE.
- Grant capture: addr, we, wdata and mask are registered at the grant edge. port_req_o is asserted from the first cycle in SERVE_x, so grant-to-request latency is 1 cycle. Port outputs are stable until ack.
- In SERVE_x, on port_ack_i high:
  - Read data is captured into x_rdata_o.
  - x_done_o pulses for exactly the next cycle.
  - port_req_o deasserts and state returns to IDLE.
  - Minimum transaction: 3 cycles from request to done (grant, ack, done).
- No back-to-back grant: IDLE is always spent for at least one cycle between transactions.
- Ack outside SERVE_x is ignored.
- Busy signals:
  - x_busy_o = x_req_i & ~x_done_o.
  - Busy is combinational, so a stage stalls in the cycle its request is raised.
  - Busy is low in the cycle done pulses.
- Streak counter:
  - Increments on each MEM grant made while if_req_i is high, saturating at MEM_STREAK_MAX.
  - Clears on any IF grant.
  - Clears on a MEM grant made while if_req_i is low.
- Request drop: if a requester drops its request mid-transaction (flush), the transaction still completes and done still pulses; the stage ignores it. Requests are never cancelled on the port.
- MEM write: port_wmask_o = mem_wmask_i captured at grant. Reads drive a zero mask and port_we_o = 0.
- IF is always a read: port_we_o = 0, mask = 0.
- Width rules: addresses pass through unmodified; no alignment checking in this block.

Test Plan:
- Reset mid-op: IF granted at 0x00000010, rst asserted before ack → next cycle port_req_o = 0, if_done_o never pulses, state IDLE; a later ack is ignored.
- Single IF fetch, ack 2 cycles after port_req_o, rdata 0x00500093 → port_addr_o = 0x10, if_done_o pulses once, if_rdata_o = 0x00500093 and holds.
- Simultaneous requests: IF @0x20, MEM read @0x1000 → MEM served first, if_busy_o high throughout; IF served in the next grant; mem_rdata_o = value returned for 0x1000.
- MEM store: we = 1, addr 0x2004, wdata 0xDEADBEEF, mask 4'b0011 → port_we_o = 1, port_wmask_o = 0011 for the whole request, mem_done_o pulses, mem_rdata_o unchanged.
- Starvation guard with MEM_STREAK_MAX = 4: mem_req_i and if_req_i held continuously → grant order MEM,MEM,MEM,MEM,IF,MEM…
- Flush: IF drops if_req_i after grant → port transaction completes, if_done_o pulses once, next IDLE grants pending MEM.
